// File: rtl/conv_pe_seq.sv
// conv_pe_seq: sequences one conv_pe through a 3x3 convolution of an IMG_W x IMG_H frame.
// Ports:
//   pclk, rst (sync, active-low)     clock / reset
//   start, busy, done, err           frame control and status
//   cfg_we, cfg_idx, cfg_data        weight load port (IDLE only)
//   w00..w22                         weight registers to conv_pe
//   rd_addr0..2 / rd_data0..2        3-port image RAM, 1-cycle read latency
//   row0_in..row2_in, pe_en          pixel column to conv_pe
//   map_va, map_out                  conv_pe results
//   out_we, out_addr, out_data       output RAM write port (same-cycle pass of map_va/map_out)
module conv_pe_seq #(
  parameter int unsigned IMG_W     = 32,
  parameter int unsigned IMG_H     = 32,
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 16,
  parameter int unsigned ROW_GAP   = 2,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_idx,
  input  logic signed [DW-1:0] cfg_data,
  output logic signed [DW-1:0] w00,
  output logic signed [DW-1:0] w01,
  output logic signed [DW-1:0] w02,
  output logic signed [DW-1:0] w10,
  output logic signed [DW-1:0] w11,
  output logic signed [DW-1:0] w12,
  output logic signed [DW-1:0] w20,
  output logic signed [DW-1:0] w21,
  output logic signed [DW-1:0] w22,
  output logic [AW-1:0]        rd_addr0,
  output logic [AW-1:0]        rd_addr1,
  output logic [AW-1:0]        rd_addr2,
  input  logic signed [DW-1:0] rd_data0,
  input  logic signed [DW-1:0] rd_data1,
  input  logic signed [DW-1:0] rd_data2,
  output logic signed [DW-1:0] row0_in,
  output logic signed [DW-1:0] row1_in,
  output logic signed [DW-1:0] row2_in,
  output logic                 pe_en,
  input  logic                 map_va,
  input  logic signed [DW-1:0] map_out,
  output logic                 out_we,
  output logic [AW-1:0]        out_addr,
  output logic signed [DW-1:0] out_data
);

  localparam int unsigned TOT = (IMG_H - 2) * (IMG_W - 2);
  localparam int unsigned TW  = $clog2(DRAIN_MAX + 1);
  localparam int unsigned GW  = $clog2(ROW_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_row, w_row_nxt;
  logic [AW-1:0]        r_col, w_col_nxt;
  logic [AW-1:0]        r_base, w_base_nxt;
  logic [GW-1:0]        r_gap, w_gap_nxt;
  logic [TW-1:0]        r_tmo, w_tmo_nxt;
  logic [AW-1:0]        r_out_cnt, w_cnt_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_issue, w_cap, w_wr;
  logic [AW-1:0]        w_a0;
  logic                 r_iss_v, r_dat_v, r_pe_en, r_busy, r_done;
  logic [AW-1:0]        r_addr0, r_addr1, r_addr2;
  logic signed [DW-1:0] r_row0, r_row1, r_row2;
  logic signed [DW-1:0] r_w [9];

  // Result capture is live only while a frame is active and results are still owed
  assign w_cap = map_va && (r_out_cnt < AW'(TOT)) &&
                 ((r_state == S_RUN) || (r_state == S_GAP) || (r_state == S_DRAIN));
  assign w_wr  = (r_state == S_IDLE) && cfg_we && (cfg_idx <= 4'd8);
  assign w_a0  = r_base + r_col;

  // Next-state and counter update logic
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_base_nxt  = r_base;
    w_gap_nxt   = r_gap;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_issue     = 1'b0;
    w_cnt_nxt   = w_cap ? (r_out_cnt + AW'(1)) : r_out_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_base_nxt  = '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (r_col == AW'(IMG_W - 1)) begin
          if (r_row < AW'(IMG_H - 3)) begin
            w_row_nxt   = r_row + AW'(1);
            w_col_nxt   = '0;
            w_base_nxt  = r_base + AW'(IMG_W);
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end else begin
            w_tmo_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_col_nxt = r_col + AW'(1);
        end
      end
      S_GAP: begin
        if (r_gap == GW'(ROW_GAP - 1)) w_state_nxt = S_RUN;
        else                           w_gap_nxt   = r_gap + GW'(1);
      end
      S_DRAIN: begin
        // Completion wins over a timeout landing in the same cycle
        if (w_cnt_nxt == AW'(TOT)) begin
          w_state_nxt = S_DONE;
        end else if (r_tmo == TW'(DRAIN_MAX - 1)) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and the issue -> RAM -> PE alignment pipeline
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_base    <= '0;
      r_gap     <= '0;
      r_tmo     <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
      r_iss_v   <= 1'b0;
      r_dat_v   <= 1'b0;
      r_pe_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr0   <= '0;
      r_addr1   <= '0;
      r_addr2   <= '0;
      r_row0    <= '0;
      r_row1    <= '0;
      r_row2    <= '0;
      for (int i = 0; i < 9; i++) r_w[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_base    <= w_base_nxt;
      r_gap     <= w_gap_nxt;
      r_tmo     <= w_tmo_nxt;
      r_out_cnt <= w_cnt_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_GAP) || (w_state_nxt == S_DRAIN);
      r_done    <= (w_state_nxt == S_DONE);
      // r_iss_v tracks the address on the bus, r_dat_v the RAM data one cycle later
      r_iss_v   <= w_issue;
      r_dat_v   <= r_iss_v;
      r_pe_en   <= r_dat_v;
      if (w_issue) begin
        r_addr0 <= w_a0;
        r_addr1 <= w_a0 + AW'(IMG_W);
        r_addr2 <= w_a0 + AW'(2 * IMG_W);
      end
      r_row0 <= r_dat_v ? rd_data0 : '0;
      r_row1 <= r_dat_v ? rd_data1 : '0;
      r_row2 <= r_dat_v ? rd_data2 : '0;
      for (int i = 0; i < 9; i++) begin
        if (w_wr && (cfg_idx == 4'(i))) r_w[i] <= cfg_data;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign pe_en    = r_pe_en;
  assign rd_addr0 = r_addr0;
  assign rd_addr1 = r_addr1;
  assign rd_addr2 = r_addr2;
  assign row0_in  = r_row0;
  assign row1_in  = r_row1;
  assign row2_in  = r_row2;
  assign w00      = r_w[0];
  assign w01      = r_w[1];
  assign w02      = r_w[2];
  assign w10      = r_w[3];
  assign w11      = r_w[4];
  assign w12      = r_w[5];
  assign w20      = r_w[6];
  assign w21      = r_w[7];
  assign w22      = r_w[8];

  // Output RAM write is a same-cycle pass of an accepted result
  assign out_we   = w_cap;
  assign out_addr = w_cap ? r_out_cnt : '0;
  assign out_data = w_cap ? map_out : '0;

endmodule

// File: tb/tb_conv_pe_seq.sv
// tb_conv_pe_seq: directed, table-driven bench for conv_pe_seq on a 4x4 frame
// with an image RAM model, a simple PE model and an output RAM model.
module tb_conv_pe_seq;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          pclk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [DW-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data0 = '0, rd_data1 = '0, rd_data2 = '0;
  logic [DW-1:0] row0_in, row1_in, row2_in;
  logic          pe_en;
  logic          map_va;
  logic [DW-1:0] map_out;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  conv_pe_seq #(.IMG_W(4), .IMG_H(4), .AW(AW), .DW(DW), .ROW_GAP(2), .DRAIN_MAX(64)) dut (
    .pclk(pclk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .w00(w00), .w01(w01), .w02(w02), .w10(w10), .w11(w11), .w12(w12),
    .w20(w20), .w21(w21), .w22(w22),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in), .pe_en(pe_en),
    .map_va(map_va), .map_out(map_out),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 pclk = ~pclk;

  // Image RAM: pixel[i] = i, one-cycle read latency
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 16'(i);
  always @(posedge pclk) begin
    rd_data0 <= mem[rd_addr0[3:0]];
    rd_data1 <= mem[rd_addr1[3:0]];
    rd_data2 <= mem[rd_addr2[3:0]];
  end

  // PE model: a result after the 3rd and 4th enabled column of each row, value 100+k
  logic          pe_auto = 1'b1;
  int            pe_limit = 4;
  int            pe_k = 0;
  int            pe_run = 0;
  logic          pe_va = 1'b0;
  logic [DW-1:0] pe_out = '0;
  logic          stray_va = 1'b0;
  logic [DW-1:0] stray_out = '0;
  always @(posedge pclk) begin
    if (start) pe_k <= 0;
    if (!pe_en) pe_run <= 0;
    else if (pe_run < 3) pe_run <= pe_run + 1;
    pe_va <= 1'b0;
    if (pe_auto && pe_en && pe_run >= 2 && pe_k < pe_limit) begin
      pe_va  <= 1'b1;
      pe_out <= 16'(100 + pe_k);
      pe_k   <= pe_k + 1;
    end
  end
  assign map_va  = pe_va | stray_va;
  assign map_out = pe_va ? pe_out : stray_out;

  // Output RAM model
  logic [DW-1:0] omem [16];
  int n_we = 0;
  always @(posedge pclk) begin
    if (out_we) begin
      omem[out_addr[3:0]] <= out_data;
      n_we <= n_we + 1;
    end
  end

  logic [DW-1:0] w_vec [9];
  assign w_vec[0] = w00; assign w_vec[1] = w01; assign w_vec[2] = w02;
  assign w_vec[3] = w10; assign w_vec[4] = w11; assign w_vec[5] = w12;
  assign w_vec[6] = w20; assign w_vec[7] = w21; assign w_vec[8] = w22;

  typedef struct {
    logic [3:0]    idx;
    logic [DW-1:0] data;
  } wt_vec_t;

  typedef struct {
    logic [AW-1:0] a0, a1, a2;
    logic          pe;
    logic [DW-1:0] r0, r2;
  } trace_t;

  wt_vec_t       wtab [10];
  logic [DW-1:0] w_exp [9];
  trace_t        tr [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic load_weights();
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      cfg_we   = 1'b1;
      cfg_idx  = wtab[i].idx;
      cfg_data = wtab[i].data;
    end
    @(negedge pclk);
    cfg_we = 1'b0;
  endtask

  task automatic check_weights(input string nm);
    for (int i = 0; i < 9; i++) chk(nm, 32'(w_vec[i]), 32'(w_exp[i]));
  endtask

  // Start a frame and observe it for max_cyc cycles; cycle 0 is the first cycle after start is sampled
  task automatic run_frame(input int max_cyc, input bit do_trace, input int stray_lo, input int stray_hi,
                           input int cfg_cyc, input int rst_cyc,
                           output int done_cyc, output int n_done, output logic err_at, output logic busy_at);
    done_cyc = -1;
    n_done   = 0;
    err_at   = 1'b0;
    busy_at  = 1'b0;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    for (int cyc = 0; cyc <= max_cyc; cyc++) begin
      if (cyc > 0) @(negedge pclk);
      stray_va  = (cyc >= stray_lo) && (cyc <= stray_hi);
      stray_out = 16'(200 + cyc - stray_lo);
      cfg_we    = (cyc == cfg_cyc);
      cfg_idx   = 4'd0;
      cfg_data  = 16'd5;
      rst       = (cyc == rst_cyc) ? 1'b0 : 1'b1;
      #1;
      if (do_trace && cyc >= 1 && cyc <= 13) begin
        chk("trace_rd_addr0", 32'(rd_addr0), 32'(tr[cyc-1].a0));
        chk("trace_rd_addr1", 32'(rd_addr1), 32'(tr[cyc-1].a1));
        chk("trace_rd_addr2", 32'(rd_addr2), 32'(tr[cyc-1].a2));
        chk("trace_pe_en",    32'(pe_en),    32'(tr[cyc-1].pe));
        chk("trace_row0_in",  32'(row0_in),  32'(tr[cyc-1].r0));
        chk("trace_row2_in",  32'(row2_in),  32'(tr[cyc-1].r2));
        chk("trace_busy",     32'(busy),     32'd1);
      end
      if (stray_va) begin
        chk("extra_out_we", 32'(out_we), (cyc - stray_lo < 4) ? 32'd1 : 32'd0);
        if (cyc - stray_lo < 4) begin
          chk("extra_out_data", 32'(out_data), 32'(stray_out));
          chk("extra_out_addr", 32'(out_addr), 32'(cyc - stray_lo));
        end
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_pe_en", 32'(pe_en), 32'd0);
        chk("abort_w00",   32'(w00),   32'd0);
        chk("abort_w22",   32'(w22),   32'd0);
        chk("abort_done",  32'(done),  32'd0);
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          err_at   = err;
          busy_at  = busy;
        end
      end
    end
    stray_va = 1'b0;
    cfg_we   = 1'b0;
    rst      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd, we0;
    logic ea, ba;

    wtab[0] = '{4'd0, 16'hFFFF}; wtab[1] = '{4'd1, 16'hFFFE}; wtab[2] = '{4'd2, 16'hFFFF};
    wtab[3] = '{4'd3, 16'h0000}; wtab[4] = '{4'd4, 16'h0000}; wtab[5] = '{4'd5, 16'h0000};
    wtab[6] = '{4'd6, 16'h0001}; wtab[7] = '{4'd7, 16'h0002}; wtab[8] = '{4'd8, 16'h0001};
    wtab[9] = '{4'd12, 16'h0007};
    w_exp[0] = 16'hFFFF; w_exp[1] = 16'hFFFE; w_exp[2] = 16'hFFFF;
    w_exp[3] = 16'h0000; w_exp[4] = 16'h0000; w_exp[5] = 16'h0000;
    w_exp[6] = 16'h0001; w_exp[7] = 16'h0002; w_exp[8] = 16'h0001;
    //              a0     a1     a2    pe    row0   row2
    tr[0]  = '{10'd0, 10'd4,  10'd8,  1'b0, 16'd0, 16'd0};
    tr[1]  = '{10'd1, 10'd5,  10'd9,  1'b0, 16'd0, 16'd0};
    tr[2]  = '{10'd2, 10'd6,  10'd10, 1'b1, 16'd0, 16'd8};
    tr[3]  = '{10'd3, 10'd7,  10'd11, 1'b1, 16'd1, 16'd9};
    tr[4]  = '{10'd3, 10'd7,  10'd11, 1'b1, 16'd2, 16'd10};
    tr[5]  = '{10'd3, 10'd7,  10'd11, 1'b1, 16'd3, 16'd11};
    tr[6]  = '{10'd4, 10'd8,  10'd12, 1'b0, 16'd0, 16'd0};
    tr[7]  = '{10'd5, 10'd9,  10'd13, 1'b0, 16'd0, 16'd0};
    tr[8]  = '{10'd6, 10'd10, 10'd14, 1'b1, 16'd4, 16'd12};
    tr[9]  = '{10'd7, 10'd11, 10'd15, 1'b1, 16'd5, 16'd13};
    tr[10] = '{10'd7, 10'd11, 10'd15, 1'b1, 16'd6, 16'd14};
    tr[11] = '{10'd7, 10'd11, 10'd15, 1'b1, 16'd7, 16'd15};
    tr[12] = '{10'd7, 10'd11, 10'd15, 1'b0, 16'd0, 16'd0};

    // Reset state
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pe_en", 32'(pe_en), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_rd_addr2", 32'(rd_addr2), 32'd0);
    chk("rst_w11", 32'(w11), 32'd0);
    rst = 1'b1;

    // Weight load, idx 12 ignored
    load_weights();
    check_weights("wload");

    // Frame with address/enable trace, cfg write while busy, full capture
    we0 = n_we;
    run_frame(40, 1'b1, -1, -2, 2, -1, dc, nd, ea, ba);
    chk("f1_done_cycle", 32'(dc), 32'd14);
    chk("f1_done_count", 32'(nd), 32'd1);
    chk("f1_err", 32'(ea), 32'd0);
    chk("f1_busy_at_done", 32'(ba), 32'd0);
    chk("f1_writes", 32'(n_we - we0), 32'd4);
    for (int i = 0; i < 4; i++) chk("f1_omem", 32'(omem[i]), 32'(100 + i));
    check_weights("busy_cfg");

    // Stray valids in IDLE
    we0 = n_we;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      stray_va  = 1'b1;
      stray_out = 16'(300 + i);
      #1;
      chk("idle_out_we", 32'(out_we), 32'd0);
    end
    @(negedge pclk);
    stray_va = 1'b0;
    chk("idle_writes", 32'(n_we - we0), 32'd0);

    // Five early results: the fifth one (beyond TOT) is dropped
    pe_auto = 1'b0;
    we0 = n_we;
    run_frame(40, 1'b0, 1, 5, -1, -1, dc, nd, ea, ba);
    chk("f2_done_cycle", 32'(dc), 32'd11);
    chk("f2_done_count", 32'(nd), 32'd1);
    chk("f2_err", 32'(ea), 32'd0);
    chk("f2_writes", 32'(n_we - we0), 32'd4);
    for (int i = 0; i < 4; i++) chk("f2_omem", 32'(omem[i]), 32'(200 + i));

    // Drain timeout: only 3 of 4 results
    pe_auto  = 1'b1;
    pe_limit = 3;
    we0 = n_we;
    run_frame(100, 1'b0, -1, -2, -1, -1, dc, nd, ea, ba);
    chk("tmo_done_cycle", 32'(dc), 32'd74);
    chk("tmo_done_count", 32'(nd), 32'd1);
    chk("tmo_err", 32'(ea), 32'd1);
    chk("tmo_writes", 32'(n_we - we0), 32'd3);
    @(negedge pclk);
    #1;
    chk("tmo_err_holds", 32'(err), 32'd1);

    // Next start clears err and completes normally
    pe_limit = 4;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    #1;
    chk("err_cleared", 32'(err), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    repeat (20) @(negedge pclk);
    #1;
    chk("f4_idle_busy", 32'(busy), 32'd0);
    chk("f4_err", 32'(err), 32'd0);

    // Reset during the second row aborts with no done
    run_frame(40, 1'b0, -1, -2, -1, 7, dc, nd, ea, ba);
    chk("abort_no_done", 32'(nd), 32'd0);
    load_weights();
    check_weights("reload");
    we0 = n_we;
    run_frame(40, 1'b0, -1, -2, -1, -1, dc, nd, ea, ba);
    chk("f5_done_cycle", 32'(dc), 32'd14);
    chk("f5_done_count", 32'(nd), 32'd1);
    chk("f5_err", 32'(ea), 32'd0);
    chk("f5_writes", 32'(n_we - we0), 32'd4);
    for (int i = 0; i < 4; i++) chk("f5_omem", 32'(omem[i]), 32'(100 + i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_pe_seq.md
Name: conv_pe_seq

Overview:
Sequencer that drives one conv_pe through a full 3x3 convolution of an IMG_W x IMG_H frame.
- Holds the nine weight registers, loaded over a config port while idle.
- Streams three vertically adjacent pixels per column from a 3-read-port image RAM into row0_in/row1_in/row2_in, gating each with pe_en.
- Writes every accepted map_va/map_out result into an output RAM, then reports done.

Parameters:
IMG_W, 32, frame width in pixels (>=3)
IMG_H, 32, frame height in pixels (>=3)
AW, 10, image/output RAM address width (IMG_W*IMG_H <= 2^AW)
DW, 16, pixel/weight/result width, signed
ROW_GAP, 2, pe_en-low cycles inserted between output rows (>=1)
DRAIN_MAX, 64, max cycles in DRAIN before timeout

Ports:
pclk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle request to begin a frame; honoured only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at frame end
err  out  1  set with done on drain timeout; cleared on next accepted start
cfg_we  in  1  weight write strobe
cfg_idx  in  4  weight index 0..8, row-major (0=w00 .. 8=w22)
cfg_data  in  DW  weight value
w00..w22  out  DW each  nine weight registers to conv_pe
rd_addr0/rd_addr1/rd_addr2  out  AW each  image RAM read addresses, rows r, r+1, r+2
rd_data0/rd_data1/rd_data2  in  DW each  image RAM data, 1-cycle read latency
row0_in/row1_in/row2_in  out  DW each  pixels to conv_pe
pe_en  out  1  conv_pe enable
map_va  in  1  conv_pe result valid
map_out  in  DW  conv_pe result
out_we  out  1  output RAM write enable
out_addr  out  AW  output RAM address
out_data  out  DW  output RAM data

Behaviour:
- Reset (rst=0 at a pclk edge): state=IDLE. All outputs, weights, row/column/gap/output/timeout counters go to 0. Reset mid-frame aborts immediately with no done pulse.
- Weights: in IDLE, cfg_we with cfg_idx<=8 writes cfg_data to that register at the next edge. cfg_idx 9..15 is ignored. cfg_we while busy is ignored. Weights hold their value across frames.
- FSM states: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE -> RUN on start. Clear r, c, out_cnt, err; busy=1.
- RUN: each cycle issue rd_addr0 = r*IMG_W+c, rd_addr1 = (r+1)*IMG_W+c, rd_addr2 = (r+2)*IMG_W+c, then c++.
  - Issue valid is registered one cycle. Next cycle pe_en=1 and rowN_in = rd_dataN, aligned with RAM latency.
  - rowN_in is registered from rd_dataN, so pe_en and rowN_in change together.
  - At c=IMG_W-1: if r<IMG_H-3, r++, c=0 -> GAP; else -> DRAIN.
- GAP: no issue for ROW_GAP cycles, then -> RUN. pe_en is therefore low for exactly ROW_GAP cycles between rows; this resets the PE window.
- PE contract: per output row the PE returns IMG_W-2 map_va pulses. Total expected TOT = (IMG_H-2)*(IMG_W-2).
- Result capture, in RUN/GAP/DRAIN: on map_va with out_cnt<TOT, drive out_we=1, out_addr=out_cnt, out_data=map_out in that same cycle (combinational pass), then out_cnt++.
  - map_va with out_cnt>=TOT is ignored.
  - map_va in IDLE/DONE is ignored.
- DRAIN: the timeout counter counts from entry.
  - out_cnt reaching TOT -> DONE.
  - Counter reaching DRAIN_MAX first -> DONE with err=1.
  - If both happen in the same cycle, the frame is a success (err=0).
- DONE: done=1 for one cycle, busy=0 -> IDLE. err holds until the next accepted start.
- start while busy or in DONE is ignored.
- Arithmetic: addresses are unsigned AW-bit products; no wrap is permitted within legal parameters. Pixels and weights pass through unmodified as signed DW.

Test Plan:
- Weight load: IMG_W=IMG_H=4. Write idx0..8 = -1,-2,-1,0,0,0,1,2,1, plus idx 12 = 7 -> w00..w22 match the list, and idx 12 has no effect. cfg_we with value 5 while busy -> weights unchanged.
- Address/enable sequence: 4x4 frame, start -> rd_addr0 shows 0,1,2,3 then 4,5,6,7; rd_addr2 shows 8..11 then 12..15. pe_en is high 4 cycles, low 2 (ROW_GAP), high 4. rowN_in equals the RAM contents one cycle after each address.
- Capture: RAM pixel[i]=i, PE model returns 2 map_va per row with map_out=100+k -> output RAM addr 0..3 holds 100..103. done pulses once with err=0 and busy deasserts the same cycle.
- Extra/stray valids: map_va pulses in IDLE, and a 5th pulse after TOT=4 -> no out_we, out_cnt stays 4.
- Timeout: PE model returns only 3 of 4 results, DRAIN_MAX=64 -> done pulses 64 cycles after DRAIN entry with err=1. The next start clears err.
- Reset mid-frame: rst=0 during the second RUN row -> next cycle busy=0, pe_en=0, weights=0, no done. A fresh start after reload completes normally.
